mem_line_arbiter: RTL and testbench

- Shares one slow 128-bit line memory between the instruction cache and the data cache. Each cache's memory-side port (read, write, line address [31:4], 128-bit wdata/rdata, ready) connects here instead of to a dedicated memory.
- Sits between the two cache instances and the single memory port at the top level.
- Serializes line transactions, holds each grant until the memory signals ready, and routes the response back to the owner.

---
 rtl/mem_line_arbiter_pkg.sv | 21 ++
 rtl/mem_line_arbiter_rr_pick2.sv | 27 ++
 rtl/mem_line_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_line_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_line_arbiter_pkg.sv
// Shared definitions for the I/D line-memory arbiter.
//   - LINE_ADDR_W / LINE_DATA_W : line address (bits [31:4]) and line data widths,
//     shared with the cache memory-side ports.
//   - REQ_I / REQ_D             : requester identifiers used for grants.
//   - arb_state_e               : arbiter FSM states.
package mem_line_arbiter_pkg;

  localparam int unsigned LINE_ADDR_W = 28;
  localparam int unsigned LINE_DATA_W = 128;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_line_arbiter_rr_pick2.sv
// Pure combinational two-way grant chooser.
// Ports:
//   req_i, req_d  in   request from I-cache / D-cache
//   last_grant    in   requester served most recently (REQ_I / REQ_D)
//   mode          in   0 = round-robin, 1 = fixed priority D over I
//   grant         out  winning requester; only meaningful when a request is present
module rr_pick2
  import mem_line_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  input  logic mode,
  output logic grant
);

  always_comb begin
    grant = REQ_I;
    if (req_i && req_d) begin
      // Under round-robin the requester that did not win last time goes next.
      grant = mode ? REQ_D : ~last_grant;
    end else if (req_d) begin
      grant = REQ_D;
    end
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares one 128-bit line memory between the I-cache and D-cache memory-side
// ports. One line transaction at a time: the owner's request is registered onto
// mem_*, held until mem_ready, the response is routed back to the owner, and a
// single RELEASE cycle follows so the request the cache is still dropping is
// not granted a second time.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_read/i_write/i_addr/i_wdata  I-cache request (held until i_ready)
//   i_rdata/i_ready             I-cache response (ready = one-cycle strobe)
//   d_*                         same set for the D-cache
//   mem_read/mem_write/mem_addr/mem_wdata  registered request to memory
//   mem_rdata/mem_ready         memory response
module mem_line_arbiter
  import mem_line_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = LINE_ADDR_W,
  parameter int unsigned DATA_W   = LINE_DATA_W,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic MODE_FIXED = (ARB_MODE != 0);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic i_req, d_req, grant;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  rr_pick2 u_pick (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_grant (last_grant_q),
    .mode       (MODE_FIXED),
    .grant      (grant)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // A read+write request from one cache is issued as the write only.
          if (grant == REQ_D) begin
            state_d     = BUSY_D;
            mem_write_d = d_write;
            mem_read_d  = d_read & ~d_write;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            state_d     = BUSY_I;
            mem_write_d = i_write;
            mem_read_d  = i_read & ~i_write;
            mem_addr_d  = i_addr;
            mem_wdata_d = i_wdata;
          end
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_d      = RELEASE;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          last_grant_d = REQ_I;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d      = RELEASE;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          last_grant_d = REQ_D;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_I;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Ready is passed through combinationally to the owner only.
  assign i_ready = (state_q == BUSY_I) && mem_ready;
  assign d_ready = (state_q == BUSY_D) && mem_ready;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Scoreboard bench for mem_line_arbiter (round-robin instance u_rr plus a
// fixed-priority instance u_fp).
module tb_mem_line_arbiter;
  import mem_line_arbiter_pkg::*;

  localparam int unsigned AW = LINE_ADDR_W;
  localparam int unsigned DW = LINE_DATA_W;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic          i_ready, d_ready;
  logic          mem_read, mem_write, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          fi_read, fd_read, fi_ready, fd_ready;
  logic [DW-1:0] fi_rdata, fd_rdata;
  logic          f_mem_read, f_mem_write, f_mem_ready;
  logic [AW-1:0] f_mem_addr;
  logic [DW-1:0] f_mem_wdata, f_mem_rdata;

  mem_line_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mem_line_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .i_read(fi_read), .i_write(1'b0), .i_addr(28'h0000111), .i_wdata('0),
    .i_rdata(fi_rdata), .i_ready(fi_ready),
    .d_read(fd_read), .d_write(1'b0), .d_addr(28'h0000222), .d_wdata('0),
    .d_rdata(fd_rdata), .d_ready(fd_ready),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata), .mem_ready(f_mem_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory contents are a fixed function of the line address.
  function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
    return {a, 4'hA, ~a, 4'h5, a ^ 28'h5A5A5A5, 4'h3, 16'hC0DE, a[15:0]};
  endfunction

  // Reference model state: outstanding request per cache, the owner the rules
  // say must hold the memory, and the last completed owner.
  req_t exp_i[$];
  req_t exp_d[$];
  int   owner = -1;
  logic model_last = REQ_I;
  logic snap_i = 1'b0, snap_d = 1'b0;
  int   fixed_lat = -1;
  int   grant_log[$];
  int   mem_starts = 0;
  req_t cur;

  initial forever begin
    @(posedge clk);
    snap_i = i_read | i_write;
    snap_d = d_read | d_write;
  end

  task automatic start_request();
    int exp_own;
    mem_starts++;
    if (snap_i && snap_d) exp_own = (model_last == REQ_I) ? 1 : 0;
    else if (snap_d)      exp_own = 1;
    else if (snap_i)      exp_own = 0;
    else                  exp_own = -1;
    grant_log.push_back(exp_own);
    checks++;
    if (exp_own == 0 && exp_i.size() > 0) begin
      cur = exp_i[0];
      owner = 0;
    end else if (exp_own == 1 && exp_d.size() > 0) begin
      cur = exp_d[0];
      owner = 1;
    end else begin
      failures++;
      $display("FAIL grant_unexpected actual=mem_req required=no_request owner=%0d", exp_own);
      owner = -1;
      cur.rd = mem_read; cur.wr = mem_write; cur.addr = mem_addr; cur.wdata = mem_wdata;
    end
  endtask

  // Memory responder: latency fixed_lat cycles, or random 0..4.
  initial begin : mem_model
    int cnt, lat;
    bit active;
    cnt = 0; lat = 0; active = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ready = 1'b0;
        active = 0;
        owner = -1;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
      end else begin
        if (!active && (mem_read || mem_write)) begin
          active = 1;
          cnt = 0;
          lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
          start_request();
        end
        if (active) begin
          check("mem_ctl", {mem_read, mem_write}, {cur.rd & ~cur.wr, cur.wr});
          check("mem_addr", mem_addr, cur.addr);
          check("mem_wdata", mem_wdata, cur.wdata);
          if (cnt == lat) begin
            mem_ready = 1'b1;
            mem_rdata = line_of(mem_addr);
            active = 0;
          end else begin
            cnt++;
          end
        end
      end
    end
  end

  task automatic take_ready(input int who, input logic [DW-1:0] data);
    req_t e;
    checks++;
    if (owner != who) begin
      failures++;
      $display("FAIL ready_owner actual=%0d required=%0d", who, owner);
    end else begin
      if (who == 0) e = exp_i.pop_front();
      else          e = exp_d.pop_front();
      check("rdata", data, line_of(e.addr));
      model_last = (who == 1) ? REQ_D : REQ_I;
      owner = -1;
    end
  endtask

  // Response monitor.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (i_ready) take_ready(0, i_rdata);
      if (d_ready) take_ready(1, d_rdata);
    end
  end

  // One cache transaction: raise, wait for ready, drop 1 (+extra) cycles later.
  task automatic do_txn(input int who, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int extra, input bit scramble, input bit first_chk);
    req_t e;
    int n;
    bit got;
    e.rd = rd; e.wr = wr; e.addr = a; e.wdata = wd;
    @(negedge clk);
    if (who == 0) begin
      exp_i.push_back(e);
      i_read = rd; i_write = wr; i_addr = a; i_wdata = wd;
    end else begin
      exp_d.push_back(e);
      d_read = rd; d_write = wr; d_addr = a; d_wdata = wd;
    end
    n = 0;
    got = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      #1;
      n++;
      got = (who == 0) ? (i_ready === 1'b1) : (d_ready === 1'b1);
      if (first_chk && n == 1)
        check("issue_next_cycle", {mem_read, mem_write, mem_addr}, {rd & ~wr, wr, a});
      if (scramble && n == 2) begin
        if (who == 0) begin i_addr = ~a; i_wdata = ~wd; end
        else          begin d_addr = ~a; d_wdata = ~wd; end
      end
    end
    if (who == 0) check("ready_i_seen", got, 1'b1);
    else          check("ready_d_seen", got, 1'b1);
    repeat (1 + extra) @(negedge clk);
    if (who == 0) begin i_read = 1'b0; i_write = 1'b0; end
    else          begin d_read = 1'b0; d_write = 1'b0; end
  endtask

  // Fixed-priority instance memory: answers in the first busy cycle.
  initial begin
    f_mem_ready = 1'b0;
    f_mem_rdata = {4{32'h0F0F1234}};
    forever begin
      @(negedge clk);
      if (!rst_n || f_mem_ready) f_mem_ready = 1'b0;
      else if (f_mem_read || f_mem_write) f_mem_ready = 1'b1;
    end
  end

  initial begin
    int s, n, sel;
    bit got;
    req_t e;
    i_read = 1'b1; i_write = 1'b0; i_addr = 28'h0000123; i_wdata = '1;
    d_read = 1'b0; d_write = 1'b1; d_addr = 28'h0000456; d_wdata = '1;
    fi_read = 1'b1; fd_read = 1'b1;

    // Reset held with requests driven.
    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_ctl", {mem_read, mem_write}, 2'b00);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ready", {i_ready, d_ready}, 2'b00);
    check("rst_fp", {f_mem_read, f_mem_write, fi_ready, fd_ready}, 4'b0000);
    @(negedge clk);
    i_read = 1'b0; d_write = 1'b0; fi_read = 1'b0; fd_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_last = REQ_I;
    repeat (2) @(negedge clk);

    // Single I read, 5-cycle memory, inputs changed mid-transaction.
    fixed_lat = 5;
    do_txn(0, 1'b1, 1'b0, 28'h0000040, '0, 0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);

    // Contention after reset: last_grant = I, so D goes first.
    fixed_lat = -1;
    grant_log.delete();
    fork
      do_txn(0, 1'b1, 1'b0, 28'h0000080, '0, 0, 1'b0, 1'b0);
      do_txn(1, 1'b0, 1'b1, 28'h00000C0, {4{32'hDEADBEEF}}, 0, 1'b0, 1'b0);
    join
    check("order_len", grant_log.size(), 2);
    check("order_first_d", grant_log[0], 1);
    check("order_second_i", grant_log[1], 0);

    // Stale request: D holds write one cycle past ready.
    repeat (2) @(negedge clk);
    s = mem_starts;
    do_txn(1, 1'b0, 1'b1, 28'h0000100, {4{$urandom}}, 1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("stale_no_regrant", mem_starts - s, 1);

    // Reset two cycles into BUSY_I (last_grant is D at this point).
    fixed_lat = 10;
    e.rd = 1'b1; e.wr = 1'b0; e.addr = 28'h00002A0; e.wdata = '0;
    @(negedge clk);
    exp_i.push_back(e);
    i_read = 1'b1; i_addr = 28'h00002A0;
    repeat (3) @(negedge clk);
    #1;
    check("rstbusy_pre_read", mem_read, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstbusy_mem_read", mem_read, 1'b0);
    check("rstbusy_mem_addr", mem_addr, 0);
    check("rstbusy_i_ready", i_ready, 1'b0);
    i_read = 1'b0;
    exp_i.delete();
    exp_d.delete();
    model_last = REQ_I;
    owner = -1;
    repeat (2) @(negedge clk);
    #1;
    check("rstbusy_no_ready", {i_ready, d_ready}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    fixed_lat = -1;
    grant_log.delete();
    fork
      do_txn(0, 1'b1, 1'b0, 28'h0000300, '0, 0, 1'b0, 1'b0);
      do_txn(1, 1'b1, 1'b0, 28'h0000340, '0, 0, 1'b0, 1'b0);
    join
    check("post_rst_first_d", grant_log[0], 1);
    check("post_rst_second_i", grant_log[1], 0);

    // Random traffic from both caches.
    fork
      begin
        for (int k = 0; k < 25; k++) begin
          int r;
          r = int'($urandom_range(1, 3));
          do_txn(0, logic'(r & 1), logic'((r >> 1) & 1), AW'($urandom), {4{$urandom}},
                 int'($urandom_range(0, 1)), 1'b0, 1'b0);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        for (int k = 0; k < 25; k++) begin
          int r;
          r = int'($urandom_range(1, 3));
          do_txn(1, logic'(r & 1), logic'((r >> 1) & 1), AW'($urandom), {4{$urandom}},
                 int'($urandom_range(0, 1)), 1'b0, 1'b0);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join
    repeat (4) @(negedge clk);
    check("queues_drained", exp_i.size() + exp_d.size(), 0);

    // Fixed priority: D re-requests continuously, I waits until D stops.
    @(negedge clk);
    fi_read = 1'b1;
    fd_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      got = 0;
      while (!got && n < 50) begin
        @(negedge clk);
        #1;
        n++;
        got = (fi_ready === 1'b1) || (fd_ready === 1'b1);
      end
      sel = (k < 3) ? 2 : 1;
      check("fp_grant", {fd_ready, fi_ready}, sel[1:0]);
      if (k == 3) check("fp_i_rdata", fi_rdata, {4{32'h0F0F1234}});
      @(negedge clk);
      if (k < 3) fd_read = 1'b0;
      else       fi_read = 1'b0;
      @(negedge clk);
      if (k < 2) fd_read = 1'b1;
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
